// File: rtl/alu_mc_if.sv
// Issue/result bundle of the multi-cycle ALU: the EX stage drives operands and start,
// and the ALU returns the hi/lo result pair, flags and the busy/done handshake.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             overflow;
    logic             div_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, ctl, a, b,
        input  result, result_hi, zero, overflow, div_zero, busy, done
    );

    modport slave (
        input  start, ctl, a, b,
        output result, result_hi, zero, overflow, div_zero, busy, done
    );
endinterface

// File: rtl/alu_mc.sv
// EX-stage ALU: single-cycle logic/arith/shift ops plus iterative shift-add MULTU and
// restoring DIVU, one iteration per clock while busy stalls the front of the pipe.
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input logic   clk,
    input logic   rst,
    alu_mc_if.slave bus
);
    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SLL  = 4'b0011;
    localparam logic [3:0] CTL_SRL  = 4'b0100;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_MULU = 4'b1000;
    localparam logic [3:0] CTL_DIVU = 4'b1001;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic             is_div;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x, y, s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x, y, d);
        return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
    endfunction

    logic signed [WIDTH-1:0] sa, sb, sum, diff;
    assign sa   = bus.a;
    assign sb   = bus.b;
    assign sum  = sa + sb;
    assign diff = sa - sb;

    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_ovf, sc_dz;
    logic             launch_multi;

    assign launch_multi = (bus.ctl == CTL_MULU) || ((bus.ctl == CTL_DIVU) && (bus.b != '0));

    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_dz  = 1'b0;
        case (bus.ctl)
            CTL_AND: sc_res = bus.a & bus.b;
            CTL_OR:  sc_res = bus.a | bus.b;
            CTL_ADD: begin
                sc_res = sum;
                sc_ovf = add_ovf(sa, sb, sum);
            end
            CTL_SUB: begin
                sc_res = diff;
                sc_ovf = sub_ovf(sa, sb, diff);
            end
            // Direct signed compare, so the sign of a wrapped difference never matters
            CTL_SLT: sc_res = (sa < sb) ? WIDTH'(1) : '0;
            CTL_SLL: sc_res = bus.a << bus.b[SHW-1:0];
            CTL_SRL: sc_res = bus.a >> bus.b[SHW-1:0];
            CTL_DIVU: begin
                sc_res = '1;
                sc_hi  = bus.a;
                sc_dz  = 1'b1;
            end
            default: ;
        endcase
    end

    // One iteration: hi_r is product-hi / partial remainder, lo_r is multiplier / dividend-quotient
    logic [WIDTH:0]   mul_t, rem_sh, trial;
    logic             q_bit;
    logic [WIDTH-1:0] nx_hi, nx_lo;

    always_comb begin
        mul_t  = lo_r[0] ? ({1'b0, hi_r} + {1'b0, opnd}) : {1'b0, hi_r};
        rem_sh = {hi_r, lo_r[WIDTH-1]};
        trial  = rem_sh - {1'b0, opnd};
        q_bit  = ~trial[WIDTH];
        if (is_div) begin
            nx_hi = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            nx_lo = {lo_r[WIDTH-2:0], q_bit};
        end else begin
            nx_hi = mul_t[WIDTH:1];
            nx_lo = {mul_t[0], lo_r[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            is_div        <= 1'b0;
            opnd          <= '0;
            hi_r          <= '0;
            lo_r          <= '0;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.zero      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.div_zero  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (launch_multi) begin
                            is_div   <= (bus.ctl == CTL_DIVU);
                            opnd     <= (bus.ctl == CTL_DIVU) ? bus.b : bus.a;
                            lo_r     <= (bus.ctl == CTL_DIVU) ? bus.a : bus.b;
                            hi_r     <= '0;
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= RUN;
                        end else begin
                            bus.result    <= sc_res;
                            bus.result_hi <= sc_hi;
                            bus.zero      <= (sc_res == '0);
                            bus.overflow  <= sc_ovf;
                            bus.div_zero  <= sc_dz;
                            bus.done      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    hi_r <= nx_hi;
                    lo_r <= nx_lo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        bus.result    <= nx_lo;
                        bus.result_hi <= nx_hi;
                        bus.zero      <= (nx_lo == '0);
                        bus.overflow  <= 1'b0;
                        bus.div_zero  <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboarded bench for alu_mc at WIDTH=32 and WIDTH=8: stimulus pushes hand-computed
// results with their expected done cycle, per-instance monitors pop on done.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32)) if32();
    alu_mc_if #(.WIDTH(8))  if8();

    alu_mc #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        ov;
        logic        dz;
        int          bsy;
        int          cyc;
    } exp_t;

    exp_t sb32[$];
    exp_t sb8[$];
    exp_t e32, e8;
    logic ed32, ed8;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   busy32 = 0;
    int   busy8  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor, 32-bit instance
    initial forever begin
        @(negedge clk);
        if (rst) begin
            busy32 = 0;
        end else begin
            while (sb32.size() > 0 && sb32[0].cyc < cyc) void'(sb32.pop_front());
            if (if32.busy) busy32++;
            ed32 = (sb32.size() > 0) && (sb32[0].cyc == cyc);
            chk("done32", 64'(if32.done), 64'(ed32));
            if (if32.done && sb32.size() > 0) begin
                e32 = sb32.pop_front();
                chk("result32",    64'(if32.result),    64'(e32.res));
                chk("result_hi32", 64'(if32.result_hi), 64'(e32.hi));
                chk("zero32",      64'(if32.zero),      64'(e32.z));
                chk("overflow32",  64'(if32.overflow),  64'(e32.ov));
                chk("div_zero32",  64'(if32.div_zero),  64'(e32.dz));
                chk("busy_cycles32", 64'(busy32),       64'(e32.bsy));
            end
            if (if32.done) busy32 = 0;
        end
    end

    // Monitor, 8-bit instance
    initial forever begin
        @(negedge clk);
        if (rst) begin
            busy8 = 0;
        end else begin
            while (sb8.size() > 0 && sb8[0].cyc < cyc) void'(sb8.pop_front());
            if (if8.busy) busy8++;
            ed8 = (sb8.size() > 0) && (sb8[0].cyc == cyc);
            chk("done8", 64'(if8.done), 64'(ed8));
            if (if8.done && sb8.size() > 0) begin
                e8 = sb8.pop_front();
                chk("result8",    64'(if8.result),    64'(e8.res));
                chk("result_hi8", 64'(if8.result_hi), 64'(e8.hi));
                chk("zero8",      64'(if8.zero),      64'(e8.z));
                chk("overflow8",  64'(if8.overflow),  64'(e8.ov));
                chk("div_zero8",  64'(if8.div_zero),  64'(e8.dz));
                chk("busy_cycles8", 64'(busy8),       64'(e8.bsy));
            end
            if (if8.done) busy8 = 0;
        end
    end

    task automatic issue32(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] r, input logic [31:0] h,
                           input logic z, input logic ov, input logic dz,
                           input bit push, input bit multi);
        exp_t e;
        if32.start = 1'b1;
        if32.ctl   = c;
        if32.a     = x;
        if32.b     = y;
        if (push) begin
            e.res = r; e.hi = h; e.z = z; e.ov = ov; e.dz = dz;
            e.bsy = multi ? 32 : 0;
            e.cyc = cyc + 1 + (multi ? 32 : 0);
            sb32.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic issue8(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] r, input logic [7:0] h,
                          input logic z, input logic ov, input bit multi);
        exp_t e;
        if8.start = 1'b1;
        if8.ctl   = c;
        if8.a     = x;
        if8.b     = y;
        e.res = 32'(r); e.hi = 32'(h); e.z = z; e.ov = ov; e.dz = 1'b0;
        e.bsy = multi ? 8 : 0;
        e.cyc = cyc + 1 + (multi ? 8 : 0);
        sb8.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        if32.start = 1'b0;
        if8.start  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        if32.start = 1'b0;
        if8.start  = 1'b0;
        for (int i = 0; i < 200 && (sb32.size() > 0 || sb8.size() > 0); i++) begin
            @(posedge clk); #1;
        end
        chk("drain_pending", 64'(sb32.size() + sb8.size()), 64'd0);
        sb32.delete();
        sb8.delete();
    endtask

    // Returns inside the cycle where done is high, so the next issue lands on that cycle
    task automatic wait_done32();
        bit seen;
        seen = 1'b0;
        if32.start = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = if32.done;
        end
        chk("wait_done32_timeout", 64'(seen), 64'd1);
        #1;
    endtask

    initial begin
        if32.start = 1'b0; if32.ctl = 4'h0; if32.a = '0; if32.b = '0;
        if8.start  = 1'b0; if8.ctl  = 4'h0; if8.a  = '0; if8.b  = '0;

        @(negedge clk);
        chk("rst_result32", 64'(if32.result),    64'd0);
        chk("rst_hi32",     64'(if32.result_hi), 64'd0);
        chk("rst_busy32",   64'(if32.busy),      64'd0);
        chk("rst_done32",   64'(if32.done),      64'd0);
        chk("rst_flags32",  64'({if32.zero, if32.overflow, if32.div_zero}), 64'd0);
        chk("rst_result8",  64'(if8.result),     64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Back-to-back single-cycle ops
        issue32(4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 0, 1, 0, 1, 0);
        issue32(4'b0110, 32'h5,         32'h5,         32'h0,         0, 1, 0, 0, 1, 0);
        issue32(4'b0111, 32'hFFFF_FFFD, 32'h2,         32'h1,         0, 0, 0, 0, 1, 0);
        issue32(4'b0111, 32'h2,         32'hFFFF_FFFD, 32'h0,         0, 1, 0, 0, 1, 0);
        issue32(4'b0011, 32'h1,         32'h25,        32'h20,        0, 0, 0, 0, 1, 0);
        issue32(4'b0100, 32'h8000_0000, 32'd31,        32'h1,         0, 0, 0, 0, 1, 0);
        issue32(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         0, 1, 0, 0, 1, 0);
        issue32(4'b0000, 32'hF0F0,      32'hFF00,      32'hF000,      0, 0, 0, 0, 1, 0);
        issue32(4'b0001, 32'hF0F0,      32'hFF00,      32'hFFF0,      0, 0, 0, 0, 1, 0);
        issue32(4'b0110, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 0, 1, 0, 1, 0);
        drain();

        // MULTU with an ignored ADD start mid-run, then starts issued in the done cycle
        issue32(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 0, 0, 0, 1, 1);
        idle(3);
        issue32(4'b0010, 32'h1, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        wait_done32();
        issue32(4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, 1, 1);
        wait_done32();
        issue32(4'b1001, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 0, 0, 1, 1, 0);
        drain();

        // Reset in the middle of a MULTU aborts it
        issue32(4'b1000, 32'h1234, 32'h5678, 0, 0, 0, 0, 0, 1, 1);
        idle(9);
        rst = 1'b1;
        #1;
        chk("abort_result32", 64'(if32.result),    64'd0);
        chk("abort_hi32",     64'(if32.result_hi), 64'd0);
        chk("abort_busy32",   64'(if32.busy),      64'd0);
        chk("abort_done32",   64'(if32.done),      64'd0);
        chk("abort_flags32",  64'({if32.zero, if32.overflow, if32.div_zero}), 64'd0);
        sb32.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        issue32(4'b1001, 32'd9, 32'd3, 32'd3, 32'd0, 0, 0, 0, 1, 1);
        drain();

        // 8-bit instance
        issue8(4'b1000, 8'd200, 8'd200, 8'h40, 8'h9C, 0, 0, 1);
        drain();
        issue8(4'b0010, 8'h7F, 8'h01, 8'h80, 8'h00, 0, 1, 0);
        drain();

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the next pipeline generation; sits in EX stage.
- Single-cycle ops: AND/OR/ADD/SUB/SLT/SLL/SRL, plus iterative unsigned MULTU (shift-add) and DIVU (restoring).
- Start/done handshake. busy is used by hazard unit to stall IF/ID/EX while a multi-cycle op runs.
- Registered outputs, hi/lo result pair, signed overflow and divide-by-zero flags.

Parameters:
WIDTH, 32, datapath width in bits (>=4, power of 2)
SHW, $clog2(WIDTH), shift-amount / iteration-counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  launch op; sampled only when busy=0
ctl  input  4  operation code, sampled with start
a  input  WIDTH  operand A
b  input  WIDTH  operand B
result  output  WIDTH  low result (product lo / quotient for MULTU/DIVU)
result_hi  output  WIDTH  product hi / remainder; 0 for single-cycle ops
zero  output  1  result==0 (result_hi ignored)
overflow  output  1  signed overflow, ADD/SUB only
div_zero  output  1  DIVU with b==0
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse: outputs updated this cycle

Behaviour:
- Reset (async, any state): state IDLE, all outputs 0, counter and internal regs 0. Reset mid-op aborts it; no done is issued.
- ctl codes and single-cycle results:
  - 0000 AND = a&b; 0001 OR = a|b.
  - 0010 ADD = a+b mod 2^WIDTH; 0110 SUB = a-b.
  - 0111 SLT = 1 if signed a < signed b, else 0. Computed without overflow error.
  - 0011 SLL = a << b[SHW-1:0]; 0100 SRL = a >> b[SHW-1:0] (logical).
  - 1000 MULTU; 1001 DIVU.
  - Any other code: single-cycle, result=0, all flags 0.
- overflow: ADD when a,b same sign and sum sign differs; SUB when a,b differ in sign and diff sign differs from a. 0 for all other ops.
- FSM has two states, IDLE and RUN.
  - IDLE, start=1, single-cycle op: on that edge result/result_hi/flags are registered and done=1 next cycle. Stay IDLE. Back-to-back starts give one result per cycle.
  - IDLE, start=1, MULTU or DIVU with b!=0: latch a, b; clear acc; counter=0; go RUN; busy=1 from next cycle.
  - IDLE, start=1, DIVU with b==0: single-cycle. result={WIDTH{1}}, result_hi=a, div_zero=1, done next cycle.
  - RUN: one iteration per edge, counter increments.
    - MULTU: add multiplicand if lsb of multiplier set, then shift the 2*WIDTH accumulator right.
    - DIVU: shift remainder left, trial subtract, set quotient bit.
  - On the edge completing iteration WIDTH (counter==WIDTH-1): register final hi/lo, update zero, clear overflow/div_zero, done=1, busy=0, return to IDLE.
  - Latency: done visible WIDTH edges after the start edge. busy=1 for exactly WIDTH cycles.
- start while busy=1 is ignored entirely; no queuing. a/b/ctl changes during RUN have no effect.
- start in the same cycle done=1 (state IDLE) is accepted normally.
- done is 0 in every cycle not directly following a completing edge.
- Outputs hold their last value until the next completion.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=1 -> next cycle result=0x80000000, overflow=1, zero=0, done=1 for one cycle. Then SUB a=5 b=5 back-to-back -> result=0, zero=1, overflow=0.
- SLT a=0xFFFFFFFD (-3) b=2 -> result=1. SLT a=2 b=-3 -> 0. SLL a=1 b=0x25 -> result=0x20 (shift 5). SRL a=0x80000000 b=31 -> 1. ctl=1111 -> result=0.
- MULTU a=b=0xFFFFFFFF -> busy=1 for 32 cycles, done 32 edges after start, result_hi=0xFFFFFFFE, result=0x00000001. A start pulse with ADD at cycle 5 of RUN is ignored: no extra done, final values unchanged.
- DIVU a=100 b=7 -> after 32 cycles result=14, result_hi=2, div_zero=0. DIVU a=0x1234 b=0 -> next cycle result=0xFFFFFFFF, result_hi=0x1234, div_zero=1, busy never 1.
- Assert rst at cycle 10 of a MULTU -> all outputs 0 immediately, busy=0, no done. After release, DIVU 9/3 completes normally: result=3, result_hi=0.
- WIDTH=8 instance: MULTU a=200 b=200 -> done 8 edges after start, result_hi=0x9C, result=0x40. ADD 0x7F+1 -> 0x80, overflow=1.
